// File: rtl/spm_program_loader.sv
// Boot loader: streams a length-prefixed, checksummed image into SRAM.
// The CPU is held in reset until a valid image has been written.
module spm_program_loader #(
  parameter int                   word_size = 8,
  parameter logic [word_size-1:0] base_addr = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [word_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_data,
  output logic                 mem_write,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {IDLE, LEN, LOAD, CHECK, DONE, ERR} state_t;

  state_t               state_q, state_d;
  logic [word_size-1:0] len_q, len_d;
  logic [word_size-1:0] cnt_q, cnt_d;
  logic [word_size-1:0] sum_q, sum_d;
  logic [word_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] mem_addr_q, mem_addr_d;
  logic [word_size-1:0] mem_data_q, mem_data_d;
  logic                 mem_write_q, mem_write_d;
  logic                 in_ready_q, in_ready_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 accept;
  logic [word_size-1:0] check_sum;

  assign accept    = in_valid && in_ready_q;
  assign check_sum = sum_q + in_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      in_ready_q  <= 1'b0;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          cnt_d   = '0;
          sum_d   = '0;
          addr_d  = base_addr;
        end
      end
      LEN: begin
        if (accept) begin
          len_d   = in_data;
          state_d = (in_data == '0) ? CHECK : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          mem_addr_d  = addr_q;
          mem_data_d  = in_data;
          mem_write_d = 1'b1;
          sum_d       = check_sum;
          addr_d      = addr_q + 1'b1;
          cnt_d       = cnt_q + 1'b1;
          // len_q is at least 1 here, so len_q-1 never wraps
          if (cnt_q == len_q - 1'b1) state_d = CHECK;
        end
      end
      CHECK: begin
        if (accept) state_d = (check_sum == '0) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are decoded from the next state and registered with it.
  always_comb begin
    in_ready_d = (state_d == LEN) || (state_d == LOAD) || (state_d == CHECK);
    busy_d     = in_ready_d;
    done_d     = (state_d == DONE);
    cpu_rst_d  = (state_d == DONE);
    error_d    = (state_d == ERR);
  end

  assign in_ready  = in_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_write = mem_write_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/spm_program_loader.md
Name: spm_program_loader

Overview:
Boot-time loader that sits directly upstream of the stored-program machine. It streams a program image byte-by-byte into the SRAM through the memory write port. It holds the CPU in reset until the image is fully written and its checksum is verified. The CPU's rst input is driven from this block's cpu_rst output.

Parameters:
word_size, 8, data/address width in bits; matches the machine word.
base_addr, 8'h00, first SRAM address written.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous active-low reset; sampled on rising clk.
start  input  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
in_data  input  word_size  incoming image byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader can accept a byte this cycle.
mem_addr  output  word_size  SRAM write address; registered.
mem_data  output  word_size  SRAM write data; registered.
mem_write  output  1  SRAM write strobe; one-cycle pulse per data byte; registered.
cpu_rst  output  1  active-low reset to the CPU; 0 holds the CPU in reset.
busy  output  1  high in LEN, LOAD and CHECK.
done  output  1  high in DONE.
error  output  1  high in ERR.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - in_ready=0, mem_write=0, mem_addr=0, mem_data=0.
  - cpu_rst=0, busy=0, done=0, error=0.
  - Byte counter and checksum cleared.
  - Applies in any state, including mid-load. No further writes are issued.
- Handshake: a byte transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is a registered state decode: 1 in LEN, LOAD and CHECK; 0 in IDLE, DONE and ERR.
  - in_valid with in_ready=0 is ignored; the byte is not consumed.
- Image format: length byte N, then N data bytes, then checksum byte C.
  - Valid image: (sum of data bytes + C) mod 2^word_size == 0.
- States:
  - IDLE: start -> LEN. Clear the counter, clear the checksum, set next address = base_addr.
  - LEN: on accept, latch N. N==0 -> CHECK; otherwise -> LOAD.
  - LOAD: on each accept:
    - mem_data<=in_data, mem_addr<=next address, mem_write<=1 in the following cycle (one-cycle write latency).
    - checksum += in_data; next address increments; counter increments.
    - When counter reaches N (the Nth byte accepted) -> CHECK.
  - CHECK: on accept:
    - If checksum + in_data == 0 mod 2^word_size -> DONE; otherwise -> ERR.
    - No memory write occurs.
  - DONE: cpu_rst=1 (CPU released), done=1. start -> LEN, and cpu_rst returns to 0 on the same edge.
  - ERR: error=1, cpu_rst stays 0. start -> LEN, and error clears.
- mem_write:
  - Deasserted in every cycle with no LOAD accept.
  - Back-to-back accepts give back-to-back write pulses at consecutive addresses.
  - The last write pulse occurs in the first cycle of CHECK.
- Address arithmetic is modulo 2^word_size: base_addr=8'hFE with N=4 writes FE, FF, 00, 01.
- N=255 writes 255 bytes; N is never interpreted as 256.
- start while busy is ignored.
- start in IDLE while in_valid=1: the byte is not consumed, because in_ready is still 0 that cycle.
- mem_addr and mem_data hold their last value when mem_write=0.
- cpu_rst, busy, done and error are registered state decodes, valid one cycle after the transition edge.

Test Plan:
1. Reset, then start, then stream 03,11,22,33,9A (sum 66+9A=00 mod 256):
   - Writes 11@00, 22@01, 33@02, each a one-cycle mem_write.
   - done=1, cpu_rst=1, error=0.
   - in_ready=0 afterwards.
2. Same stream with checksum 9B:
   - Three writes occur.
   - Ends in ERR: error=1, cpu_rst=0.
   - A second start with the correct image reaches DONE with error=0.
3. Start, then 00, 00:
   - No mem_write pulses.
   - done=1 two accepts after start.
4. base_addr=FE, image 04,01,02,03,04,F6:
   - Writes at FE, FF, 00, 01.
   - DONE.
5. Hold in_valid low for random gaps and issue start mid-LOAD:
   - Writes occur only on accept cycles.
   - The mid-LOAD start has no effect.
   - Final memory contents equal the image.
6. Assert rst=0 after the 2nd data byte of a 5-byte load:
   - At the next edge all outputs return to reset values.
   - No further mem_write.
   - A subsequent start and full image completes normally.
